// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches from a combinational imem and queues {pc, instr} pairs for decode
module instr_fetch_unit #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              halt,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [1:0]        queue_count
);
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] q_pc [2];
   logic [DATA_W-1:0] q_instr [2];
   logic              rd_ptr;
   logic              wr_ptr;
   logic [1:0]        count;
   logic              push;
   logic              pop;
   // Handshake decode; a full queue still takes a fetch when its head leaves this cycle
   always_comb begin
      out_valid   = count != 2'd0;
      pop         = out_valid & out_ready;
      push        = !halt & !redirect_valid & ((count != 2'd2) | pop);
      out_instr   = out_valid ? q_instr[rd_ptr] : '0;
      out_pc      = out_valid ? q_pc[rd_ptr] : '0;
      queue_count = count;
      imem_addr   = pc;
   end
   // PC, pointers and occupancy; redirect flushes the queue and retargets the PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= RESET_PC;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (redirect_valid) begin
         pc     <= redirect_pc;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         pc     <= push ? pc + ADDR_W'(1) : pc;
         wr_ptr <= push ? ~wr_ptr : wr_ptr;
         rd_ptr <= pop ? ~rd_ptr : rd_ptr;
         count  <= count + 2'(push) - 2'(pop);
      end
   end
   // Queue storage; stale slots are never visible because the head is gated by count
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]    <= pc;
         q_instr[wr_ptr] <= imem_data;
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench comparing the delivered instruction stream against a fetch model
module tb_instr_fetch_unit;
   localparam int AW = 5;
   localparam int DW = 32;

   typedef struct {
      logic [AW-1:0] pc;
      logic [DW-1:0] instr;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          halt = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          out_ready = 1'b0;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_data;
   logic          out_valid;
   logic [DW-1:0] out_instr;
   logic [AW-1:0] out_pc;
   logic [1:0]    queue_count;
   logic [DW-1:0] mem [32];

   int            compared = 0;
   int            mismatched = 0;
   ent_t          exp_q[$];
   int            mc;
   logic [AW-1:0] mpc;
   logic          m_pop;
   logic          m_push;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr];

   instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
      .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .queue_count(queue_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: the fetch stream is pc, pc+1, ... with a two-deep buffer toward decode
   assign m_pop  = (mc != 0) && out_ready;
   assign m_push = !halt && !redirect_valid && (mc < 2 || m_pop);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mc  <= 0;
         mpc <= '0;
         exp_q.delete();
      end else if (redirect_valid) begin
         mc  <= 0;
         mpc <= redirect_pc;
         exp_q.delete();
      end else begin
         if (m_push) exp_q.push_back('{mpc, mem[mpc]});
         mpc <= m_push ? mpc + AW'(1) : mpc;
         mc  <= mc + int'(m_push) - int'(m_pop);
      end
   end

   // Monitor: every presented head must be the oldest fetched entry not yet consumed
   always @(negedge clk) begin
      if (rst_n) begin
         check("valid", 64'(out_valid), 64'(mc != 0));
         check("queue_count", 64'(queue_count), 64'(mc));
         check("imem_addr", 64'(imem_addr), 64'(mpc));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL head: got pc %0h with no entry expected at %0t", out_pc, $time);
            end else begin
               check("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
               check("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
               if (out_ready) void'(exp_q.pop_front());
            end
         end else begin
            check("empty_pc", 64'(out_pc), 64'd0);
            check("empty_instr", 64'(out_instr), 64'd0);
         end
      end
   end

   task automatic drive(input logic h, input logic rdy, input logic rv, input logic [AW-1:0] rp);
      halt           = h;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rp;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_checks();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(queue_count), 64'd0);
      check("rst_addr", 64'(imem_addr), 64'd0);
      check("rst_pc", 64'(out_pc), 64'd0);
      check("rst_instr", 64'(out_instr), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      reset_checks();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_checks();
      rst_n = 1'b1;
      repeat (8) drive(1'b0, 1'b1, 1'b0, '0);
      do_reset();
      repeat (5) drive(1'b0, 1'b0, 1'b0, '0);
      check("stall_addr", 64'(imem_addr), 64'd2);
      check("stall_count", 64'(queue_count), 64'd2);
      repeat (6) drive(1'b0, 1'b1, 1'b0, '0);
      repeat (2) drive(1'b0, 1'b0, 1'b0, '0);
      drive(1'b0, 1'b1, 1'b1, AW'(20));
      repeat (4) drive(1'b0, 1'b1, 1'b0, '0);
      drive(1'b0, 1'b1, 1'b1, AW'(30));
      repeat (6) drive(1'b0, 1'b1, 1'b0, '0);
      repeat (2) drive(1'b0, 1'b0, 1'b0, '0);
      repeat (4) drive(1'b1, 1'b1, 1'b0, '0);
      drive(1'b1, 1'b1, 1'b1, AW'(9));
      repeat (2) drive(1'b1, 1'b1, 1'b0, '0);
      repeat (4) drive(1'b0, 1'b1, 1'b0, '0);
      drive(1'b0, 1'b1, 1'b1, AW'(5));
      repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
      check("pre_rst_addr", 64'(imem_addr), 64'd7);
      check("pre_rst_count", 64'(queue_count), 64'd2);
      do_reset();
      repeat (5) drive(1'b0, 1'b1, 1'b0, '0);
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 32; i++) if ($urandom_range(0, 63) == 0) mem[i] = $urandom;
         drive($urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 11) == 0, AW'($urandom));
      end
      repeat (4) drive(1'b0, 1'b1, 1'b0, '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
